// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: command/state encodings and command classification helpers for the stack sequencer.
package stack_seq_pkg;
   typedef enum logic [2:0] {NOP, PUSH, POP, DUP, DROP, OVER, BINOP, RSVD} cmd_t;
   typedef enum logic [2:0] {IDLE, XH, XL, YH, YL, ZH, ZL} state_t;
   function automatic logic cmd_legal(cmd_t c, int unsigned d, int unsigned max_d);
      return c == NOP ? 1'b1 :
             c == PUSH ? d < max_d :
             (c == POP || c == DROP) ? d >= 1 :
             c == DUP ? (d >= 1 && d < max_d) :
             c == OVER ? (d >= 2 && d < max_d) :
             c == BINOP ? d >= 2 : 1'b0;
   endfunction
   function automatic logic cmd_grows(cmd_t c);
      return c == PUSH || c == DUP || c == OVER;
   endfunction
   function automatic logic cmd_shrinks(cmd_t c);
      return c == POP || c == DROP || c == BINOP;
   endfunction
   function automatic logic cmd_writes(cmd_t c);
      return cmd_grows(c) || c == BINOP;
   endfunction
endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if: command handshake plus Memory-side bus of the stack sequencer.
interface stack_sequencer_if #(parameter int P_W = 16, parameter int DW = 7);
   logic [2:0]     i_CMD;
   logic [P_W-1:0] i_DATA;
   logic           f_VALID;
   logic           o_READY;
   logic           o_DONE;
   logic           o_ERROR;
   logic [P_W-1:0] o_RESULT;
   logic [DW-1:0]  o_DEPTH;
   logic           o_XCLOCK;
   logic           o_YCLOCK;
   logic           o_ZCLOCK;
   logic [15:0]    o_RADDR;
   logic [15:0]    o_WADDR;
   logic [P_W-1:0] o_DATA;
   logic           o_WRITE;
   logic [P_W-1:0] i_OP1;
   logic [P_W-1:0] i_OP2;
   modport master (
      output i_CMD, i_DATA, f_VALID, i_OP1, i_OP2,
      input  o_READY, o_DONE, o_ERROR, o_RESULT, o_DEPTH, o_XCLOCK, o_YCLOCK, o_ZCLOCK,
             o_RADDR, o_WADDR, o_DATA, o_WRITE
   );
   modport slave (
      input  i_CMD, i_DATA, f_VALID, i_OP1, i_OP2,
      output o_READY, o_DONE, o_ERROR, o_RESULT, o_DEPTH, o_XCLOCK, o_YCLOCK, o_ZCLOCK,
             o_RADDR, o_WADDR, o_DATA, o_WRITE
   );
endinterface

// File: rtl/stack_phase_gen.sv
// stack_phase_gen: 7-state phase ring producing registered X/Y/Z phase clocks, ready and done.
module stack_phase_gen
   import stack_seq_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   valid,
   output state_t state,
   output logic   ready,
   output logic   done,
   output logic   xclk,
   output logic   yclk,
   output logic   zclk
);
   state_t state_q, state_d;
   logic   xclk_q, xclk_d, yclk_q, yclk_d, zclk_q, zclk_d;
   always_comb begin
      state_d = state_q == IDLE ? (valid ? XH : IDLE) :
                state_q == XH ? XL :
                state_q == XL ? YH :
                state_q == YH ? YL :
                state_q == YL ? ZH :
                state_q == ZH ? ZL : IDLE;
      xclk_d = state_d == XH;
      yclk_d = state_d == YH;
      zclk_d = state_d == ZH;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         xclk_q  <= 1'b0;
         yclk_q  <= 1'b0;
         zclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         xclk_q  <= xclk_d;
         yclk_q  <= yclk_d;
         zclk_q  <= zclk_d;
      end
   end
   assign state = state_q;
   assign ready = state_q == IDLE;
   assign done  = state_q == ZL;
   assign xclk  = xclk_q;
   assign yclk  = yclk_q;
   assign zclk  = zclk_q;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: one-command-at-a-time stack controller driving the data-stack Memory.
module stack_sequencer
   import stack_seq_pkg::*;
#(
   parameter int          P_W     = 16,
   parameter logic [15:0] P_BASE  = 16'd0,
   parameter int          P_DEPTH = 64
) (
   input logic              c_CLOCK,
   input logic              f_RESET,
   stack_sequencer_if.slave bus
);
   localparam int DW = $clog2(P_DEPTH + 1);
   state_t         state;
   logic           accept;
   cmd_t           cmd_q, cmd_d;
   logic [P_W-1:0] data_q, data_d, op1_q, op1_d, op2_q, op2_d;
   logic [P_W-1:0] result_q, result_d, wdata_q, wdata_d;
   logic           err_q, err_d, write_q, write_d;
   logic [DW-1:0]  depth_q, depth_d;
   logic [15:0]    raddr_q, raddr_d, waddr_q, waddr_d, tos_up;
   stack_phase_gen u_phase (
      .clk   (c_CLOCK),
      .rst   (f_RESET),
      .valid (bus.f_VALID),
      .state (state),
      .ready (bus.o_READY),
      .done  (bus.o_DONE),
      .xclk  (bus.o_XCLOCK),
      .yclk  (bus.o_YCLOCK),
      .zclk  (bus.o_ZCLOCK)
   );
   assign accept = bus.f_VALID && bus.o_READY;
   assign tos_up = P_BASE + 16'(depth_q);
   // Legality is frozen at acceptance; an illegal command still runs its phases but has no effect.
   always_comb begin
      cmd_d    = cmd_q;
      data_d   = data_q;
      err_d    = err_q;
      raddr_d  = raddr_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      result_d = result_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      write_d  = write_q;
      depth_d  = depth_q;
      if (accept) begin
         cmd_d   = cmd_t'(bus.i_CMD);
         data_d  = bus.i_DATA;
         err_d   = !cmd_legal(cmd_t'(bus.i_CMD), int'(depth_q), P_DEPTH);
         raddr_d = depth_q != '0 ? tos_up - 16'd1 : P_BASE;
      end
      if (state == XL) begin
         op1_d    = bus.i_OP1;
         op2_d    = bus.i_OP2;
         result_d = (cmd_q == POP && !err_q) ? bus.i_OP1 : result_q;
      end
      if (state == YL) begin
         write_d = !err_q && cmd_writes(cmd_q);
         if (write_d) begin
            waddr_d = cmd_q == BINOP ? tos_up - 16'd2 : tos_up;
            wdata_d = (cmd_q == PUSH || cmd_q == BINOP) ? data_q : cmd_q == DUP ? op1_q : op2_q;
         end
      end
      if (state == ZL) begin
         write_d = 1'b0;
         depth_d = err_q ? depth_q :
                   cmd_grows(cmd_q) ? depth_q + 1'b1 :
                   cmd_shrinks(cmd_q) ? depth_q - 1'b1 : depth_q;
      end
   end
   always_ff @(posedge c_CLOCK) begin
      if (f_RESET) begin
         cmd_q    <= NOP;
         data_q   <= '0;
         err_q    <= 1'b0;
         raddr_q  <= P_BASE;
         op1_q    <= '0;
         op2_q    <= '0;
         result_q <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         depth_q  <= '0;
      end else begin
         cmd_q    <= cmd_d;
         data_q   <= data_d;
         err_q    <= err_d;
         raddr_q  <= raddr_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         result_q <= result_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         write_q  <= write_d;
         depth_q  <= depth_d;
      end
   end
   assign bus.o_ERROR  = state == ZL && err_q;
   assign bus.o_RESULT = result_q;
   assign bus.o_DEPTH  = depth_q;
   assign bus.o_RADDR  = raddr_q;
   assign bus.o_WADDR  = waddr_q;
   assign bus.o_DATA   = wdata_q;
   assign bus.o_WRITE  = write_q;
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: randomized and directed stimulus checked against a stack-level reference model.
module tb_stack_sequencer;
   localparam int C_NOP = 0, C_PUSH = 1, C_POP = 2, C_DUP = 3, C_DROP = 4, C_OVER = 5, C_BINOP = 6, C_RSVD = 7;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   stack_sequencer_if #(.P_W(16), .DW(7)) bus ();
   stack_sequencer #(.P_W(16), .P_BASE(16'd0), .P_DEPTH(64)) dut (
      .c_CLOCK (clk),
      .f_RESET (rst),
      .bus     (bus)
   );
   logic [15:0] mem [64];
   initial for (int i = 0; i < 64; i++) mem[i] = 16'h0;
   assign bus.i_OP1 = mem[bus.o_RADDR[5:0]];
   assign bus.i_OP2 = mem[6'(bus.o_RADDR - 16'd1)];
   always @(negedge bus.o_ZCLOCK) if (bus.o_WRITE) mem[bus.o_WADDR[5:0]] <= bus.o_DATA;
   int n_chk = 0, n_pass = 0;
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
   endtask
   function automatic bit legal(int c, int d);
      case (c)
         C_NOP:          return 1;
         C_PUSH:         return d < 64;
         C_POP, C_DROP:  return d >= 1;
         C_DUP:          return d >= 1 && d < 64;
         C_OVER:         return d >= 2 && d < 64;
         C_BINOP:        return d >= 2;
         default:        return 0;
      endcase
   endfunction
   logic [15:0] stk[$];
   logic [15:0] m_res = 16'h0;
   int ph = 0, cyc = 0, md = 0, e_cmd = 0;
   int n_acc = 0, acc_prev = 0, acc_last = 0, done_last = 0, n_err = 0, n_wr = 0, n_done = 0;
   bit chk_rst = 0, e_err = 0, e_wr = 0;
   logic [15:0] e_wa, e_wd, e_res, e_ra, e_data;
   always @(negedge clk) begin
      cyc++;
      if (bus.o_ERROR) n_err++;
      if (bus.o_WRITE && bus.o_ZCLOCK) n_wr++;
      if (bus.o_DONE) begin n_done++; done_last = cyc; end
      if (rst) begin
         stk.delete();
         m_res = 16'h0;
         ph = 0;
         chk_rst = 1;
      end else if (ph == 0) begin
         if (chk_rst) begin
            chk("rst_raddr", bus.o_RADDR, 0);
            chk("rst_waddr", bus.o_WADDR, 0);
            chk("rst_wdata", bus.o_DATA, 0);
            chk_rst = 0;
         end
         chk("idle_ready", bus.o_READY, 1);
         chk("idle_strobes", {bus.o_XCLOCK, bus.o_YCLOCK, bus.o_ZCLOCK, bus.o_DONE, bus.o_ERROR, bus.o_WRITE}, 0);
         chk("idle_depth", bus.o_DEPTH, stk.size());
         chk("idle_result", bus.o_RESULT, m_res);
         if (bus.f_VALID) begin
            md = stk.size();
            e_cmd = bus.i_CMD;
            e_data = bus.i_DATA;
            e_err = !legal(e_cmd, md);
            e_ra = md > 0 ? 16'(md - 1) : 16'h0;
            e_res = m_res;
            e_wr = 0;
            e_wa = 16'h0;
            e_wd = 16'h0;
            if (!e_err) case (e_cmd)
               C_PUSH:  begin e_wr = 1; e_wa = 16'(md); e_wd = e_data; end
               C_POP:   e_res = stk[md-1];
               C_DUP:   begin e_wr = 1; e_wa = 16'(md); e_wd = stk[md-1]; end
               C_OVER:  begin e_wr = 1; e_wa = 16'(md); e_wd = stk[md-2]; end
               C_BINOP: begin e_wr = 1; e_wa = 16'(md - 2); e_wd = e_data; end
               default: ;
            endcase
            n_acc++;
            acc_prev = acc_last;
            acc_last = cyc;
            ph = 1;
         end
      end else begin
         chk("busy_ready", bus.o_READY, 0);
         chk("xclock", bus.o_XCLOCK, 32'(ph == 1));
         chk("yclock", bus.o_YCLOCK, 32'(ph == 3));
         chk("zclock", bus.o_ZCLOCK, 32'(ph == 5));
         chk("done", bus.o_DONE, 32'(ph == 6));
         chk("error", bus.o_ERROR, 32'(ph == 6 && e_err));
         chk("write", bus.o_WRITE, 32'(ph >= 5 && e_wr));
         chk("busy_depth", bus.o_DEPTH, stk.size());
         chk("raddr", bus.o_RADDR, e_ra);
         chk("result", bus.o_RESULT, ph >= 3 ? e_res : m_res);
         if (ph >= 5 && e_wr) begin
            chk("waddr", bus.o_WADDR, e_wa);
            chk("wdata", bus.o_DATA, e_wd);
         end
         if (ph == 6) begin
            if (!e_err) case (e_cmd)
               C_PUSH:  stk.push_back(e_data);
               C_POP:   begin m_res = e_res; void'(stk.pop_back()); end
               C_DROP:  void'(stk.pop_back());
               C_DUP:   stk.push_back(stk[stk.size()-1]);
               C_OVER:  stk.push_back(stk[stk.size()-2]);
               C_BINOP: begin void'(stk.pop_back()); void'(stk.pop_back()); stk.push_back(e_data); end
               default: ;
            endcase
            ph = 0;
         end else ph++;
      end
   end
   task automatic do_cmd(input int c, input logic [15:0] d, input int hold);
      int s;
      bit ok;
      s = n_acc;
      ok = 0;
      bus.i_CMD = 3'(c);
      bus.i_DATA = d;
      bus.f_VALID = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         if (n_acc != s) begin ok = 1; break; end
      end
      chk("accept_in_time", 32'(ok), 1);
      repeat (hold) @(posedge clk);
      #1 bus.f_VALID = 1'b0;
   endtask
   task automatic wait_idle();
      repeat (8) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int e0, w0, a0, d0;
      bus.i_CMD = 3'(C_PUSH);
      bus.i_DATA = 16'hDEAD;
      bus.f_VALID = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      bus.f_VALID = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_cmd(C_PUSH, 16'h1234, 0);
      wait_idle();
      chk("push_done_latency", 32'(done_last - acc_last), 6);
      chk("push_depth", bus.o_DEPTH, 1);
      chk("push_mem0", mem[0], 16'h1234);
      do_cmd(C_DROP, 16'h0, 0);
      do_cmd(C_PUSH, 16'd5, 0);
      do_cmd(C_PUSH, 16'd7, 0);
      wait_idle();
      chk("accept_spacing", 32'(acc_last - acc_prev), 7);
      do_cmd(C_BINOP, 16'd12, 0);
      wait_idle();
      chk("binop_depth", bus.o_DEPTH, 1);
      chk("binop_mem0", mem[0], 16'd12);
      do_cmd(C_POP, 16'h0, 0);
      wait_idle();
      chk("pop_result", bus.o_RESULT, 16'd12);
      chk("pop_depth", bus.o_DEPTH, 0);
      do_cmd(C_PUSH, 16'hAAAA, 0);
      do_cmd(C_DUP, 16'h0, 0);
      do_cmd(C_OVER, 16'h0, 0);
      wait_idle();
      chk("dup_over_cells", {mem[0], mem[1], mem[2]}, 48'hAAAA_AAAA_AAAA);
      chk("dup_over_depth", bus.o_DEPTH, 3);
      do_reset();
      e0 = n_err; w0 = n_wr;
      do_cmd(C_POP, 16'h0, 0);
      do_cmd(C_DROP, 16'h0, 0);
      do_cmd(C_BINOP, 16'h55, 0);
      wait_idle();
      chk("underflow_errors", 32'(n_err - e0), 3);
      chk("underflow_writes", 32'(n_wr - w0), 0);
      chk("underflow_depth", bus.o_DEPTH, 0);
      while (stk.size() < 64) do_cmd(C_PUSH, 16'($urandom), 0);
      wait_idle();
      chk("full_depth", bus.o_DEPTH, 64);
      e0 = n_err; w0 = n_wr;
      do_cmd(C_PUSH, 16'h1111, 0);
      do_cmd(C_DUP, 16'h0, 0);
      do_cmd(C_OVER, 16'h0, 0);
      wait_idle();
      chk("overflow_errors", 32'(n_err - e0), 3);
      chk("overflow_writes", 32'(n_wr - w0), 0);
      chk("overflow_depth", bus.o_DEPTH, 64);
      e0 = n_err; w0 = n_wr;
      do_cmd(C_RSVD, 16'h0, 0);
      wait_idle();
      chk("rsvd_error", 32'(n_err - e0), 1);
      chk("rsvd_writes", 32'(n_wr - w0), 0);
      a0 = n_acc; d0 = n_done;
      do_cmd(C_DROP, 16'h0, 5);
      wait_idle();
      chk("held_valid_accepts", 32'(n_acc - a0), 1);
      chk("held_valid_dones", 32'(n_done - d0), 1);
      do_cmd(C_PUSH, 16'hBEEF, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_depth", bus.o_DEPTH, 0);
      chk("midrst_ready", bus.o_READY, 1);
      chk("midrst_write", bus.o_WRITE, 0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 150; i++) begin
         int c;
         c = $urandom_range(0, 7);
         if ($urandom_range(0, 2) == 0) c = C_PUSH;
         do_cmd(c, 16'($urandom), 0);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 9)) @(posedge clk);
            #1;
         end
      end
      wait_idle();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
